// File: rtl/cuckoo_pkg.sv
// Shared types and constants for the cuckoo lookup result path.
//   hit_rec_t      : one captured result cycle (hit mask, suffix flags, byte offset)
//   HIT_*          : bit positions inside hit_rec_t.hit / .sfx
//   OFF_W          : default payload byte-offset width
//   lowest_hit_idx : priority pick of the next hit to report
package cuckoo_pkg;

    localparam int OFF_W = 16;

    localparam logic [1:0] HIT_CASE_A   = 2'd0;
    localparam logic [1:0] HIT_CASE_B   = 2'd1;
    localparam logic [1:0] HIT_NOCASE_A = 2'd2;
    localparam logic [1:0] HIT_NOCASE_B = 2'd3;

    typedef struct packed {
        logic [3:0]       hit;     // {nocaseB, nocaseA, caseB, caseA}
        logic [3:0]       sfx;     // suffix flag, same bit order as hit
        logic [OFF_W-1:0] offset;  // byte offset that started the lookup
    } hit_rec_t;

    // Index of the lowest set bit; caseA has the highest priority.
    function automatic logic [1:0] lowest_hit_idx(input logic [3:0] mask);
        logic [1:0] idx;
        casez (mask)
            4'b???1: idx = HIT_CASE_A;
            4'b??10: idx = HIT_CASE_B;
            4'b?100: idx = HIT_NOCASE_A;
            4'b1000: idx = HIT_NOCASE_B;
            default: idx = HIT_CASE_A;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/cuckoo_match_collector_if.sv
// Match-event handshake bus from the collector to the rule-reporting logic.
//   ev_valid/ev_ready : valid/ready handshake, one event per accepted cycle
//   ev_offset         : payload byte offset of the hit
//   ev_nocase/ev_port : which lookup path / port produced the hit
//   ev_suffix         : suffix flag of the hit
interface cuckoo_match_collector_if #(
    parameter int OFF_W = 16
);
    logic             ev_valid;
    logic             ev_ready;
    logic [OFF_W-1:0] ev_offset;
    logic             ev_nocase;
    logic             ev_port;
    logic             ev_suffix;

    modport master (
        output ev_valid, ev_offset, ev_nocase, ev_port, ev_suffix,
        input  ev_ready
    );

    modport slave (
        input  ev_valid, ev_offset, ev_nocase, ev_port, ev_suffix,
        output ev_ready
    );
endinterface

// File: rtl/match_rec_fifo.sv
// Synchronous first-word-fall-through FIFO for hit records.
//   clk/rst        : clock, asynchronous active-low reset
//   push/wdata     : write; accepted when not full, or when full with a pop
//   pop/rdata      : rdata is the head entry; pop is ignored when empty
//   full/empty     : occupancy flags
//   count          : number of stored entries (0..DEPTH)
module match_rec_fifo #(
    parameter  int WIDTH = 24,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wptr_r;
    logic [AW-1:0]    rptr_r;
    logic [CW-1:0]    count_r;
    logic             push_s;
    logic             pop_s;

    // Qualify requests; a full FIFO still accepts a push when it pops on the same edge.
    always_comb begin
        pop_s  = pop && (count_r != {CW{1'b0}});
        push_s = push && ((count_r != CW'(DEPTH)) || pop_s);
    end

    // Storage array and write pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wptr_r <= {AW{1'b0}};
        end else if (push_s) begin
            mem_r[wptr_r] <= wdata;
            wptr_r        <= wptr_r + AW'(1);
        end
    end

    // Read pointer and occupancy count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr_r  <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (pop_s) begin
                rptr_r <= rptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata = mem_r[rptr_r];
    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == {CW{1'b0}});
    assign count = count_r;

endmodule

// File: rtl/cuckoo_match_collector.sv
// Realigns cuckoo engine results with the payload byte offset that started
// each lookup, buffers hit records and serializes them into match events.
//   clk, rst (async active-low)
//   enable, pkt_start                  : engine issue strobe / packet start
//   compare_out[_nocase], suffix[_nocase]: per-port results, LATENCY after issue
//   ev (master)                        : one match event per handshake
//   almost_full                        : throttle request for enable
//   overflow, drop_count, stat_clr     : drop statistics and their clear
// OFF_W must equal cuckoo_pkg::OFF_W, since the record type is shared.
module cuckoo_match_collector
    import cuckoo_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int OFF_W   = cuckoo_pkg::OFF_W,
    parameter int DEPTH   = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic                            pkt_start,
    input  logic [1:0]                      compare_out,
    input  logic [1:0]                      suffix,
    input  logic [1:0]                      compare_out_nocase,
    input  logic [1:0]                      suffix_nocase,
    input  logic                            stat_clr,
    cuckoo_match_collector_if.master        ev,
    output logic                            almost_full,
    output logic                            overflow,
    output logic [15:0]                     drop_count
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int AF_THR = DEPTH - LATENCY - 1;

    typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} ser_state_e;

    logic [OFF_W-1:0] off_cnt_r;
    logic             started_r;
    logic [OFF_W-1:0] issue_off_s;
    logic [LATENCY-1:0] dl_vld_r;
    logic [OFF_W-1:0] dl_off_r [LATENCY];

    logic [3:0]  hit_s, sfx_s, mask_r, mask_after_s, mask_nxt_s;
    logic        cap_s, hs_s, load_s, drop_s, push_s;
    logic [1:0]  emit_idx_s, nxt_idx_s;
    hit_rec_t    cap_rec_s, rec_r, rec_nxt_s, fifo_rdata_s;
    logic        fifo_full_s, fifo_empty_s;
    logic [CNT_W-1:0] fifo_cnt_s, cnt_nxt_s;
    ser_state_e  state_r, state_nxt_s;

    logic             ev_valid_r, ev_nocase_r, ev_port_r, ev_suffix_r;
    logic [OFF_W-1:0] ev_offset_r;
    logic             almost_full_r, overflow_r;
    logic [15:0]      drop_cnt_r;

    // Offset of the byte issued this cycle. Until the first byte after reset the
    // all-ones counter is treated as "one before zero" instead of saturated.
    always_comb begin
        if (pkt_start || !started_r) begin
            issue_off_s = {OFF_W{1'b0}};
        end else if (off_cnt_r == {OFF_W{1'b1}}) begin
            issue_off_s = off_cnt_r;
        end else begin
            issue_off_s = off_cnt_r + OFF_W'(1);
        end
    end

    // Offset counter, advanced only by issued bytes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            off_cnt_r <= {OFF_W{1'b1}};
            started_r <= 1'b0;
        end else if (enable) begin
            off_cnt_r <= issue_off_s;
            started_r <= 1'b1;
        end
    end

    // Tag delay line tracking the engine pipeline; shifts every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dl_vld_r <= {LATENCY{1'b0}};
            for (int i = 0; i < LATENCY; i++) begin
                dl_off_r[i] <= {OFF_W{1'b0}};
            end
        end else begin
            dl_vld_r[0] <= enable;
            dl_off_r[0] <= issue_off_s;
            for (int i = 1; i < LATENCY; i++) begin
                dl_vld_r[i] <= dl_vld_r[i-1];
                dl_off_r[i] <= dl_off_r[i-1];
            end
        end
    end

    // Capture, serializer next state and FIFO push/pop/drop decisions.
    always_comb begin
        hit_s            = {compare_out_nocase, compare_out};
        sfx_s            = {suffix_nocase, suffix};
        // Results for invalid tags are repeats from stalled addresses.
        cap_s            = dl_vld_r[LATENCY-1] && (hit_s != 4'b0000);
        cap_rec_s.hit    = hit_s;
        cap_rec_s.sfx    = sfx_s;
        cap_rec_s.offset = dl_off_r[LATENCY-1];

        emit_idx_s = lowest_hit_idx(mask_r);
        hs_s       = (mask_r != 4'b0000) && ev.ev_ready;
        if (hs_s) begin
            mask_after_s = mask_r & ~(4'b0001 << emit_idx_s);
        end else begin
            mask_after_s = mask_r;
        end

        // Refill on the same edge the last hit leaves, so events stay back to back.
        load_s = (mask_after_s == 4'b0000) && !fifo_empty_s;
        if (load_s) begin
            mask_nxt_s = fifo_rdata_s.hit;
            rec_nxt_s  = fifo_rdata_s;
        end else begin
            mask_nxt_s = mask_after_s;
            rec_nxt_s  = rec_r;
        end
        nxt_idx_s = lowest_hit_idx(mask_nxt_s);

        drop_s    = cap_s && fifo_full_s && !load_s;
        push_s    = cap_s && !drop_s;
        cnt_nxt_s = fifo_cnt_s + CNT_W'(push_s) - CNT_W'(load_s);
    end

    match_rec_fifo #(
        .WIDTH ($bits(hit_rec_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (load_s),
        .wdata (cap_rec_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_cnt_s)
    );

    // Serializer state: IDLE with an empty mask, HOLD while hits remain.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (load_s) begin
                    state_nxt_s = S_HOLD;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_HOLD: begin
                if ((mask_after_s == 4'b0000) && !load_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_HOLD;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Serializer registers and the registered event outputs derived from them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= S_IDLE;
            mask_r      <= 4'b0000;
            rec_r       <= '0;
            ev_valid_r  <= 1'b0;
            ev_offset_r <= {OFF_W{1'b0}};
            ev_nocase_r <= 1'b0;
            ev_port_r   <= 1'b0;
            ev_suffix_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            mask_r      <= mask_nxt_s;
            rec_r       <= rec_nxt_s;
            ev_valid_r  <= (mask_nxt_s != 4'b0000);
            ev_offset_r <= rec_nxt_s.offset;
            ev_nocase_r <= nxt_idx_s[1];
            ev_port_r   <= nxt_idx_s[0];
            ev_suffix_r <= rec_nxt_s.sfx[nxt_idx_s];
        end
    end

    // Back-pressure flag and drop statistics; stat_clr beats a same-cycle drop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            almost_full_r <= 1'b0;
            overflow_r    <= 1'b0;
            drop_cnt_r    <= 16'h0000;
        end else begin
            almost_full_r <= (cnt_nxt_s >= CNT_W'(AF_THR));
            if (stat_clr) begin
                overflow_r <= 1'b0;
                drop_cnt_r <= 16'h0000;
            end else if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_cnt_r != 16'hFFFF) begin
                    drop_cnt_r <= drop_cnt_r + 16'h0001;
                end
            end
        end
    end

    assign ev.ev_valid  = ev_valid_r;
    assign ev.ev_offset = ev_offset_r;
    assign ev.ev_nocase = ev_nocase_r;
    assign ev.ev_port   = ev_port_r;
    assign ev.ev_suffix = ev_suffix_r;
    assign almost_full  = almost_full_r;
    assign overflow     = overflow_r;
    assign drop_count   = drop_cnt_r;

endmodule

// File: tb/tb_cuckoo_match_collector.sv
// Self-checking bench for cuckoo_match_collector: expected events are queued
// when a byte is issued and compared when the DUT hands an event over.
module tb_cuckoo_match_collector;

    localparam int LATENCY = 4;
    localparam int DEPTH   = 8;
    localparam int OFF_W   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable = 1'b0, pkt_start = 1'b0, stat_clr = 1'b0;
    logic [1:0]  compare_out = 2'b00, suffix = 2'b00;
    logic [1:0]  compare_out_nocase = 2'b00, suffix_nocase = 2'b00;
    logic        almost_full, overflow;
    logic [15:0] drop_count;

    cuckoo_match_collector_if #(.OFF_W(OFF_W)) ev_if ();

    cuckoo_match_collector #(
        .LATENCY (LATENCY),
        .OFF_W   (OFF_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .enable             (enable),
        .pkt_start          (pkt_start),
        .compare_out        (compare_out),
        .suffix             (suffix),
        .compare_out_nocase (compare_out_nocase),
        .suffix_nocase      (suffix_nocase),
        .stat_clr           (stat_clr),
        .ev                 (ev_if.master),
        .almost_full        (almost_full),
        .overflow           (overflow),
        .drop_count         (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] off;
        logic        nocase;
        logic        port;
        logic        sfx;
    } ev_t;

    ev_t        exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [3:0] hit_pipe [LATENCY];
    logic [3:0] sfx_pipe [LATENCY];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: issue a byte (or not), present the engine result due this cycle,
    // and queue the events this byte's hits must produce.
    task automatic step(input logic en, input logic ps, input logic [3:0] hit,
                        input logic [3:0] sfx, input logic [15:0] exp_off, input logic expect_rec);
        ev_t e;
        enable             = en;
        pkt_start          = ps;
        compare_out        = hit_pipe[LATENCY-1][1:0];
        compare_out_nocase = hit_pipe[LATENCY-1][3:2];
        suffix             = sfx_pipe[LATENCY-1][1:0];
        suffix_nocase      = sfx_pipe[LATENCY-1][3:2];
        @(posedge clk);
        for (int i = LATENCY - 1; i > 0; i--) begin
            hit_pipe[i] = hit_pipe[i-1];
            sfx_pipe[i] = sfx_pipe[i-1];
        end
        hit_pipe[0] = hit;
        sfx_pipe[0] = sfx;
        if (en && expect_rec) begin
            for (int b = 0; b < 4; b++) begin
                if (hit[b]) begin
                    e.off    = exp_off;
                    e.nocase = (b >= 2);
                    e.port   = (b == 1) || (b == 3);
                    e.sfx    = sfx[b];
                    exp_q.push_back(e);
                end
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'b0000, 4'b0000, 16'h0000, 1'b0);
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            idle(1);
            c++;
        end
        idle(3);
        check_val("drain_q_empty", exp_q.size(), 0);
        check_val("drain_ev_valid", ev_if.ev_valid, 1'b0);
    endtask

    task automatic clear_pipe();
        for (int i = 0; i < LATENCY; i++) begin
            hit_pipe[i] = 4'b0000;
            sfx_pipe[i] = 4'b0000;
        end
    endtask

    // Event monitor: a handshake happens at the next rising edge.
    always @(negedge clk) begin
        ev_t e;
        if (rst && ev_if.ev_valid && ev_if.ev_ready) begin
            check_val("ev_expected", (exp_q.size() > 0), 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_val("ev_offset", ev_if.ev_offset, e.off);
                check_val("ev_nocase", ev_if.ev_nocase, e.nocase);
                check_val("ev_port",   ev_if.ev_port,   e.port);
                check_val("ev_suffix", ev_if.ev_suffix, e.sfx);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_pipe();
        ev_if.ev_ready = 1'b1;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ev_valid", ev_if.ev_valid, 1'b0);
        check_val("rst_ev_offset", ev_if.ev_offset, 16'h0000);
        check_val("rst_almost_full", almost_full, 1'b0);
        check_val("rst_overflow", overflow, 1'b0);
        check_val("rst_drop_count", drop_count, 16'h0000);
        rst = 1'b1;

        // Single case-A hit on byte 3; ev_valid exactly LATENCY+1 edges later.
        for (int i = 0; i < 12; i++) begin
            step(i < 10, i == 0, (i == 3) ? 4'b0001 : 4'b0000, 4'b0000, 16'(i), 1'b1);
            if (i > 3) check_val("lat_ev_valid", ev_if.ev_valid, (i == 3 + LATENCY + 1));
        end
        drain(20);

        // All four hits on offset 7: order caseA, caseB, nocaseA, nocaseB.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, i == 0, (i == 7) ? 4'b1111 : 4'b0000, 4'b0110, 16'(i), 1'b1);
        end
        drain(20);

        // Enable 1,0,0,1 with hits on every result cycle: only issued bytes count.
        step(1'b1, 1'b1, 4'b0001, 4'b0000, 16'd0, 1'b1);
        step(1'b0, 1'b0, 4'b0001, 4'b0000, 16'd0, 1'b1);
        step(1'b0, 1'b0, 4'b0001, 4'b0000, 16'd0, 1'b1);
        step(1'b1, 1'b0, 4'b0001, 4'b0000, 16'd1, 1'b1);
        for (int i = 0; i < LATENCY + 2; i++) step(1'b0, 1'b0, 4'b0001, 4'b0000, 16'd0, 1'b1);
        clear_pipe();
        drain(20);

        // Stalled consumer: 12 hits, serializer + FIFO hold 9, the rest drop.
        ev_if.ev_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, i == 0, 4'b0001, 4'b0000, 16'(i), i < 9);
            if (i == 6) check_val("af_below_thr", almost_full, 1'b0);
            if (i == 7) check_val("af_at_thr", almost_full, 1'b1);
        end
        idle(LATENCY + 2);
        check_val("ovf_set", overflow, 1'b1);
        check_val("drop_cnt", drop_count, 16'd3);
        check_val("af_full", almost_full, 1'b1);
        stat_clr = 1'b1;
        idle(1);
        stat_clr = 1'b0;
        check_val("clr_overflow", overflow, 1'b0);
        check_val("clr_drop_cnt", drop_count, 16'd0);
        ev_if.ev_ready = 1'b1;
        drain(40);
        check_val("af_drained", almost_full, 1'b0);

        // Restart after offset 200, then run the counter into saturation.
        for (int i = 0; i <= 201; i++) begin
            step(1'b1, i == 0, (i == 201) ? 4'b0001 : 4'b0000, 4'b0000, 16'(i), 1'b1);
        end
        step(1'b1, 1'b1, 4'b0010, 4'b0010, 16'd0, 1'b1);
        for (int i = 1; i <= 65537; i++) begin
            step(1'b1, 1'b0, (i == 1 || i >= 65534) ? 4'b0100 : 4'b0000, 4'b0000,
                 (i > 65535) ? 16'hFFFF : 16'(i), 1'b1);
        end
        drain(40);

        // Reset with an event pending and records queued.
        ev_if.ev_ready = 1'b0;
        step(1'b1, 1'b1, 4'b0000, 4'b0000, 16'd0, 1'b0);
        step(1'b1, 1'b0, 4'b1000, 4'b1000, 16'd1, 1'b0);
        step(1'b1, 1'b0, 4'b1000, 4'b1000, 16'd2, 1'b0);
        step(1'b1, 1'b0, 4'b1111, 4'b1111, 16'd3, 1'b0);
        idle(LATENCY + 3);
        check_val("pre_rst_valid", ev_if.ev_valid, 1'b1);
        check_val("pre_rst_nocase", ev_if.ev_nocase, 1'b1);
        #2 rst = 1'b0;
        #1;
        check_val("mid_rst_valid", ev_if.ev_valid, 1'b0);
        check_val("mid_rst_fields", {ev_if.ev_offset, ev_if.ev_nocase, ev_if.ev_port, ev_if.ev_suffix}, 19'h0);
        check_val("mid_rst_af", almost_full, 1'b0);
        clear_pipe();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        ev_if.ev_ready = 1'b1;
        idle(12);
        check_val("post_rst_valid", ev_if.ev_valid, 1'b0);
        // First non-pkt_start byte after reset reports offset 0.
        step(1'b1, 1'b0, 4'b0001, 4'b0001, 16'd0, 1'b1);
        drain(20);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
